// File: rtl/fp16_add_arbiter_if.sv
// fp16_add_arbiter_if: requester, adder-operand and response bundle around the shared FP16 adder
interface fp16_add_arbiter_if;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [15:0] add_a, add_b, add_c;
   logic        rsp0_valid, rsp1_valid, busy;
   logic [15:0] rsp0_data, rsp1_data;
   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_c,
      input  req0_ready, req1_ready, add_a, add_b, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
   );
   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_c,
      output req0_ready, req1_ready, add_a, add_b, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
   );
endinterface

// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: round-robin sharing of one pipelined FP16 adder between two requesters
module fp16_add_arbiter #(
   parameter int LAT     = 5,
   parameter int MAX_OUT = 4
) (
   input logic                clk_59,
   input logic                rst_59,
   fp16_add_arbiter_if.slave  bus
);
   localparam int CW = $clog2(MAX_OUT + 1);
   logic [CW-1:0]  cnt0, cnt1;
   logic [LAT-1:0] tag_v, tag_p;
   logic           last_grant, elig0, elig1, grant0, grant1, ret0, ret1;
   assign elig0 = bus.req0_valid && (cnt0 < CW'(MAX_OUT));
   assign elig1 = bus.req1_valid && (cnt1 < CW'(MAX_OUT));
   // on contention the port that did not win last time goes first
   assign grant0 = elig0 && (!elig1 || last_grant);
   assign grant1 = elig1 && (!elig0 || !last_grant);
   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign ret0 = tag_v[LAT-1] && !tag_p[LAT-1];
   assign ret1 = tag_v[LAT-1] && tag_p[LAT-1];
   assign bus.busy = (|tag_v) || (|cnt0) || (|cnt1);
   always_ff @(posedge clk_59) begin
      if (rst_59) begin
         bus.add_a      <= '0;
         bus.add_b      <= '0;
         tag_v          <= '0;
         tag_p          <= '0;
         last_grant     <= 1'b1;
         cnt0           <= '0;
         cnt1           <= '0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp0_data  <= '0;
         bus.rsp1_data  <= '0;
      end else begin
         bus.add_a      <= grant0 ? bus.req0_a : grant1 ? bus.req1_a : 16'h0;
         bus.add_b      <= grant0 ? bus.req0_b : grant1 ? bus.req1_b : 16'h0;
         tag_v          <= {tag_v[LAT-2:0], grant0 || grant1};
         tag_p          <= {tag_p[LAT-2:0], grant1};
         if (grant0 || grant1) last_grant <= grant1;
         cnt0           <= cnt0 + CW'(grant0) - CW'(ret0);
         cnt1           <= cnt1 + CW'(grant1) - CW'(ret1);
         bus.rsp0_valid <= ret0;
         bus.rsp1_valid <= ret1;
         if (ret0) bus.rsp0_data <= bus.add_c;
         if (ret1) bus.rsp1_data <= bus.add_c;
      end
   end
endmodule

// File: tb/tb_fp16_add_arbiter.sv
// tb_fp16_add_arbiter: scenario tasks against a transaction-level model with a stand-in FP16 adder
module tb_fp16_add_arbiter;
   localparam int LAT = 5;
   logic clk_59 = 1'b0;
   logic rst_59 = 1'b1;
   always #5 clk_59 = ~clk_59;
   fp16_add_arbiter_if ia ();
   fp16_add_arbiter_if ib ();
   fp16_add_arbiter #(.LAT(LAT), .MAX_OUT(4)) dut  (.clk_59(clk_59), .rst_59(rst_59), .bus(ia.slave));
   fp16_add_arbiter #(.LAT(LAT), .MAX_OUT(5)) dut5 (.clk_59(clk_59), .rst_59(rst_59), .bus(ib.slave));

   // positive-normal FP16 add with truncation, standing in for fpadder
   function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] x, y;
      logic [11:0] s;
      logic [4:0]  e;
      if (a[14:0] == 15'h0) return b;
      if (b[14:0] == 15'h0) return a;
      x = (a[14:0] >= b[14:0]) ? a : b;
      y = (a[14:0] >= b[14:0]) ? b : a;
      e = x[14:10];
      s = {2'b01, x[9:0]} + ({2'b01, y[9:0]} >> (x[14:10] - y[14:10]));
      if (s[11]) begin
         s = s >> 1;
         e = e + 5'd1;
      end
      return {1'b0, e, s[9:0]};
   endfunction

   function automatic logic [15:0] rnd16();
      return {1'b0, 5'($urandom_range(1, 28)), 10'($urandom)};
   endfunction

   logic [15:0] pa [LAT-1];
   logic [15:0] pb [LAT-1];
   always @(posedge clk_59) begin
      pa[0] <= fadd(ia.add_a, ia.add_b);
      pb[0] <= fadd(ib.add_a, ib.add_b);
      for (int k = 1; k < LAT - 1; k++) begin
         pa[k] <= pa[k-1];
         pb[k] <= pb[k-1];
      end
   end
   assign ia.add_c = pa[LAT-2];
   assign ib.add_c = pb[LAT-2];

   typedef struct {int p; logic [15:0] d; int due;} ent_t;
   ent_t q[$];
   int cnt[2];
   int lg, lim, sel, cyc, nchk, nerr;
   logic o_rdy0, o_rdy1, o_rv0, o_rv1, o_busy, e_rdy0, e_rdy1, e_rv0, e_rv1, e_busy;
   logic [15:0] o_rd0, o_rd1, o_adda, o_addb, e_rd0, e_rd1, e_adda, e_addb;

   task automatic drive(input logic v0, input logic v1, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1);
      ia.req0_valid = (sel == 0) && v0;
      ia.req1_valid = (sel == 0) && v1;
      ib.req0_valid = (sel == 1) && v0;
      ib.req1_valid = (sel == 1) && v1;
      ia.req0_a = a0; ia.req0_b = b0; ia.req1_a = a1; ia.req1_b = b1;
      ib.req0_a = a0; ib.req0_b = b0; ib.req1_a = a1; ib.req1_b = b1;
   endtask

   // one clock: predict grant/response from the model, then observe the DUT on the far edge
   task automatic tick(input logic v0, input logic v1, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1);
      int g;
      ent_t t;
      logic el0, el1;
      drive(v0, v1, a0, b0, a1, b1);
      #1;
      o_rdy0 = sel ? ib.req0_ready : ia.req0_ready;
      o_rdy1 = sel ? ib.req1_ready : ia.req1_ready;
      el0 = v0 && (cnt[0] < lim);
      el1 = v1 && (cnt[1] < lim);
      g = (el0 && el1) ? 1 - lg : el0 ? 0 : el1 ? 1 : -1;
      e_rdy0 = (g == 0);
      e_rdy1 = (g == 1);
      e_adda = (g == 0) ? a0 : (g == 1) ? a1 : 16'h0;
      e_addb = (g == 0) ? b0 : (g == 1) ? b1 : 16'h0;
      if (g >= 0) begin
         t.p = g;
         t.d = g ? fadd(a1, b1) : fadd(a0, b0);
         t.due = cyc + LAT;
         q.push_back(t);
         cnt[g]++;
         lg = g;
      end
      e_rv0 = 1'b0;
      e_rv1 = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         t = q.pop_front();
         if (t.p == 1) begin e_rv1 = 1'b1; e_rd1 = t.d; end
         else begin e_rv0 = 1'b1; e_rd0 = t.d; end
         cnt[t.p]--;
      end
      e_busy = (q.size() > 0);
      @(posedge clk_59);
      @(negedge clk_59);
      cyc++;
      o_rv0  = sel ? ib.rsp0_valid : ia.rsp0_valid;
      o_rv1  = sel ? ib.rsp1_valid : ia.rsp1_valid;
      o_rd0  = sel ? ib.rsp0_data  : ia.rsp0_data;
      o_rd1  = sel ? ib.rsp1_data  : ia.rsp1_data;
      o_busy = sel ? ib.busy       : ia.busy;
      o_adda = sel ? ib.add_a      : ia.add_a;
      o_addb = sel ? ib.add_b      : ia.add_b;
   endtask

   task automatic do_reset(input logic hold1);
      drive(1'b0, hold1, 16'h3C00, 16'h3C00, rnd16(), rnd16());
      rst_59 = 1'b1;
      @(posedge clk_59);
      @(negedge clk_59);
      rst_59 = 1'b0;
      cyc++;
      q.delete();
      cnt[0] = 0;
      cnt[1] = 0;
      lg = 1;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic test_reset();
      sel = 0;
      do_reset(1'b0);
      nchk++;
      if ({ia.rsp0_valid, ia.rsp1_valid, ia.busy} !== 3'b000) begin
         nerr++; $display("FAIL reset_flags got %b want 000", {ia.rsp0_valid, ia.rsp1_valid, ia.busy});
      end
      nchk++;
      if ({ia.rsp0_data, ia.rsp1_data, ia.add_a, ia.add_b} !== 64'h0) begin
         nerr++; $display("FAIL reset_data got %h want 0", {ia.rsp0_data, ia.rsp1_data, ia.add_a, ia.add_b});
      end
      nchk++;
      if ({ib.rsp0_valid, ib.rsp1_valid, ib.busy, ib.add_a, ib.rsp0_data} !== 35'h0) begin
         nerr++; $display("FAIL reset_dut5 got %h want 0", {ib.rsp0_valid, ib.rsp1_valid, ib.busy, ib.add_a, ib.rsp0_data});
      end
   endtask

   task automatic test_single();
      int hs, seen;
      sel = 0;
      do_reset(1'b0);
      hs = cyc;
      seen = 0;
      tick(1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h0, 16'h0);
      nchk++;
      if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin
         nerr++; $display("FAIL single_ready got %b%b want 10", o_rdy0, o_rdy1);
      end
      nchk++;
      if (o_adda !== 16'h3C00 || o_addb !== 16'h3C00) begin
         nerr++; $display("FAIL single_operands got %h/%h want 3c00/3c00", o_adda, o_addb);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
         if (o_rv0 === 1'b1) begin
            seen++;
            nchk++;
            if (cyc - hs != LAT + 1 || o_rd0 !== 16'h4000) begin
               nerr++; $display("FAIL single_rsp got %h at +%0d want 4000 at +%0d", o_rd0, cyc - hs, LAT + 1);
            end
         end
         nchk++;
         if (o_rv1 !== 1'b0) begin nerr++; $display("FAIL single_rsp1 got %b want 0", o_rv1); end
      end
      nchk++;
      if (seen != 1 || o_busy !== 1'b0) begin
         nerr++; $display("FAIL single_done got pulses=%0d busy=%b want 1/0", seen, o_busy);
      end
   endtask

   task automatic test_contention();
      int n0, n1;
      sel = 0;
      do_reset(1'b0);
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b1, 16'h3C00, 16'h4000, 16'h4000, 16'h4000);
         nchk++;
         if ({o_rdy0, o_rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            nerr++; $display("FAIL contention_grant cyc %0d got %b%b want alternate", i, o_rdy0, o_rdy1);
         end
         nchk++;
         if ({o_rv0, o_rv1} !== {e_rv0, e_rv1} || (o_rv0 && o_rd0 !== 16'h4200) || (o_rv1 && o_rd1 !== 16'h4400)) begin
            nerr++; $display("FAIL contention_rsp cyc %0d got %b%b %h/%h want %b%b 4200/4400", i, o_rv0, o_rv1, o_rd0, o_rd1, e_rv0, e_rv1);
         end
         n0 += int'(o_rv0);
         n1 += int'(o_rv1);
      end
      nchk++;
      if (n0 + n1 != 20 - LAT || (n0 - n1) > 1 || (n1 - n0) > 1) begin
         nerr++; $display("FAIL contention_count got %0d/%0d want %0d total alternating", n0, n1, 20 - LAT);
      end
   endtask

   task automatic test_limit();
      int acc, ret, w0, w1;
      sel = 0;
      do_reset(1'b0);
      acc = 0; ret = 0; w0 = 0; w1 = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, 1'b0, rnd16(), rnd16(), 16'h0, 16'h0);
         acc += int'(o_rdy0);
         ret += int'(o_rv0);
         if (i < 6) w0 += int'(o_rdy0);
         else if (i < 12) w1 += int'(o_rdy0);
         nchk++;
         if (o_rdy0 !== e_rdy0 || o_rv0 !== e_rv0 || (e_rv0 && o_rd0 !== e_rd0) || o_busy !== e_busy) begin
            nerr++; $display("FAIL limit cyc %0d got rdy=%b rv=%b d=%h busy=%b want %b %b %h %b", i, o_rdy0, o_rv0, o_rd0, o_busy, e_rdy0, e_rv0, e_rd0, e_busy);
         end
         nchk++;
         if (acc - ret > 4) begin nerr++; $display("FAIL limit_outstanding got %0d want <=4", acc - ret); end
      end
      nchk++;
      if (w0 != 4 || w1 != 4) begin nerr++; $display("FAIL limit_window got %0d/%0d want 4/4", w0, w1); end
   endtask

   task automatic test_release();
      sel = 0;
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, rnd16(), rnd16(), 16'h0, 16'h0);
      tick(1'b0, 1'b1, 16'h0, 16'h0, rnd16(), rnd16());
      for (int i = 0; i < 14; i++) begin
         tick(1'b1, 1'b1, rnd16(), rnd16(), rnd16(), rnd16());
         nchk++;
         if (i == 0 && {o_rdy0, o_rdy1} !== 2'b01) begin
            nerr++; $display("FAIL release_blocked got %b%b want 01", o_rdy0, o_rdy1);
         end
         nchk++;
         if (i == 1 && {o_rdy0, o_rdy1} !== 2'b10) begin
            nerr++; $display("FAIL release_regain got %b%b want 10", o_rdy0, o_rdy1);
         end
         nchk++;
         if ({o_rdy0, o_rdy1, o_rv0, o_rv1} !== {e_rdy0, e_rdy1, e_rv0, e_rv1} || (e_rv0 && o_rd0 !== e_rd0) || (e_rv1 && o_rd1 !== e_rd1)) begin
            nerr++; $display("FAIL release cyc %0d got %b%b%b%b %h/%h want %b%b%b%b %h/%h", i, o_rdy0, o_rdy1, o_rv0, o_rv1, o_rd0, o_rd1, e_rdy0, e_rdy1, e_rv0, e_rv1, e_rd0, e_rd1);
         end
      end
   endtask

   task automatic test_reset_mid();
      sel = 0;
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'h0, 16'h0, rnd16(), rnd16());
      tick(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      do_reset(1'b1);
      nchk++;
      if ({ia.rsp0_valid, ia.rsp1_valid, ia.busy} !== 3'b000) begin
         nerr++; $display("FAIL midreset_after got %b want 000", {ia.rsp0_valid, ia.rsp1_valid, ia.busy});
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
         nchk++;
         if ({o_rv0, o_rv1, o_busy} !== 3'b000) begin
            nerr++; $display("FAIL midreset_drop cyc %0d got %b%b%b want 000", i, o_rv0, o_rv1, o_busy);
         end
      end
      tick(1'b1, 1'b1, rnd16(), rnd16(), rnd16(), rnd16());
      nchk++;
      if ({o_rdy0, o_rdy1} !== 2'b10) begin nerr++; $display("FAIL midreset_first got %b%b want 10", o_rdy0, o_rdy1); end
   endtask

   task automatic test_simul();
      sel = 1;
      lim = 5;
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, rnd16(), rnd16(), 16'h0, 16'h0);
      tick(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      for (int i = 0; i < 16; i++) begin
         if (i < 6) tick(1'b1, 1'b0, rnd16(), rnd16(), 16'h0, 16'h0);
         else tick(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
         nchk++;
         if (i == 0 && {o_rdy0, o_rv0} !== 2'b11) begin
            nerr++; $display("FAIL simul_edge got rdy=%b rv=%b want 1 1", o_rdy0, o_rv0);
         end
         nchk++;
         if (o_rdy0 !== e_rdy0 || o_rv0 !== e_rv0 || (e_rv0 && o_rd0 !== e_rd0) || o_busy !== e_busy || (e_rdy0 && o_adda !== e_adda)) begin
            nerr++; $display("FAIL simul cyc %0d got rdy=%b rv=%b d=%h busy=%b want %b %b %h %b", i, o_rdy0, o_rv0, o_rd0, o_busy, e_rdy0, e_rv0, e_rd0, e_busy);
         end
      end
      nchk++;
      if (o_busy !== 1'b0) begin nerr++; $display("FAIL simul_idle got busy=%b want 0", o_busy); end
      sel = 0;
      lim = 4;
   endtask

   task automatic test_back_to_back();
      logic v0, v1;
      sel = 0;
      do_reset(1'b0);
      for (int i = 0; i < 300; i++) begin
         v0 = (i < 280) && ($urandom_range(0, 3) != 0);
         v1 = (i < 280) && ($urandom_range(0, 2) != 0);
         tick(v0, v1, rnd16(), rnd16(), rnd16(), rnd16());
         nchk++;
         if ({o_rdy0, o_rdy1, o_rv0, o_rv1, o_busy} !== {e_rdy0, e_rdy1, e_rv0, e_rv1, e_busy} || (e_rv0 && o_rd0 !== e_rd0) || (e_rv1 && o_rd1 !== e_rd1) || o_adda !== e_adda || o_addb !== e_addb) begin
            nerr++; $display("FAIL b2b cyc %0d got %b%b%b%b%b %h/%h want %b%b%b%b%b %h/%h", i, o_rdy0, o_rdy1, o_rv0, o_rv1, o_busy, o_rd0, o_rd1, e_rdy0, e_rdy1, e_rv0, e_rv1, e_busy, e_rd0, e_rd1);
         end
      end
   endtask

   initial begin
      nchk = 0; nerr = 0; cyc = 0; sel = 0; lim = 4; lg = 1;
      drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      @(negedge clk_59);
      test_reset();
      test_single();
      test_contention();
      test_limit();
      test_release();
      test_reset_mid();
      test_simul();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
